// File: rtl/load_store_unit_pkg.sv
// Shared types, Funct3 codes and lane tables for the load/store unit.
// Imported by the LSU top, its bus interface users and load_extend.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(
    input logic       write,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    unique case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // f3[1:0] encodes the access size for every legal code
  function automatic logic f3_aligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b1;
    unique case (f3[1:0])
      2'b01:   ok = !off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(
    input logic       write,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    if (write) begin
      unique case (f3)
        F3_B:    be = 4'b0001 << off;
        F3_H:    be = 4'b0011 << off;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] d;
    d = wd;
    unique case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory valid/ready bus between the LSU (master)
// and the memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);

  logic              BusValid;
  logic              BusWrite;
  logic [ADDR_W-1:0] BusAddr;
  logic [31:0]       BusWData;
  logic [3:0]        BusByteEn;
  logic              BusReady;
  logic [31:0]       BusRData;

  modport master (
    output BusValid,
    output BusWrite,
    output BusAddr,
    output BusWData,
    output BusByteEn,
    input  BusReady,
    input  BusRData
  );

  modport slave (
    input  BusValid,
    input  BusWrite,
    input  BusAddr,
    input  BusWData,
    input  BusByteEn,
    output BusReady,
    output BusRData
  );

endinterface

// File: rtl/load_store_unit_extend.sv
// load_extend: picks the addressed byte/half of a read word
// and sign- or zero-extends it to 32 bits.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  assign shifted = rdata >> {off, 3'b000};
  assign b       = shifted[7:0];
  assign h       = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (f3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'd0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: FSM driving the data bus, stalling the PC.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               MemReq,
  input  logic               MemWrite,
  input  logic [2:0]         Funct3,
  input  logic [31:0]        ALUResult,
  input  logic [31:0]        WriteData,
  output logic [31:0]        ReadDataOut,
  output logic               Stall,
  output logic               Fault,
  output logic               BusTimeout,
  load_store_unit_if.master  bus
);

  state_t            state;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              fault_q;
  logic [31:0]       rdo_q;
  logic [31:0]       ext;
  logic              req_ok;

`ifdef LSU_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  logic          tmo_q;
  assign BusTimeout = tmo_q;
`else
  assign BusTimeout = 1'b0;
`endif

  assign req_ok = f3_legal(MemWrite, Funct3)
                & f3_aligned(Funct3, ALUResult[1:0]);

  // Reset gates Stall so the PC is released while reset is held
  assign Stall = RESET & (
                   (state == S_IDLE && MemReq)
                 | (state == S_ACCESS));

  assign bus.BusValid  = (state == S_ACCESS);
  assign bus.BusWrite  = write_q;
  assign bus.BusAddr   = addr_q;
  assign bus.BusWData  = wdata_q;
  assign bus.BusByteEn = be_q;
  assign Fault         = fault_q;
  assign ReadDataOut   = rdo_q;

  load_extend u_ext (
    .rdata (bus.BusRData),
    .off   (off_q),
    .f3    (f3_q),
    .data  (ext)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      write_q <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'b0000;
      fault_q <= 1'b0;
      rdo_q   <= 32'd0;
`ifdef LSU_TIMEOUT_EN
      cnt     <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      fault_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (MemReq && req_ok) begin
            state   <= S_ACCESS;
            write_q <= MemWrite;
            f3_q    <= Funct3;
            off_q   <= ALUResult[1:0];
            addr_q  <= ADDR_W'({ALUResult[31:2], 2'b00});
            wdata_q <= lane_data(Funct3, WriteData);
            be_q    <= byte_en(MemWrite, Funct3,
                               ALUResult[1:0]);
`ifdef LSU_TIMEOUT_EN
            cnt     <= '0;
`endif
          end else if (MemReq) begin
            state   <= S_RESP;
            fault_q <= 1'b1;
            rdo_q   <= 32'd0;
          end
        end
        S_ACCESS: begin
          if (bus.BusReady) begin
            state <= S_RESP;
            rdo_q <= write_q ? 32'd0 : ext;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt == LIM) begin
            state <= S_RESP;
            tmo_q <= 1'b1;
            rdo_q <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a response scoreboard.
// Build with LSU_TIMEOUT_EN to also exercise the bus timeout.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    logic        fault;
    logic        tmo;
    logic [31:0] rdo;
    bit          chk_rdo;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic        MemReq;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadDataOut;
  logic        Stall;
  logic        Fault;
  logic        BusTimeout;

  int   tests;
  int   fails;
  exp_t sb[$];

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .MemReq      (MemReq),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .ReadDataOut (ReadDataOut),
    .Stall       (Stall),
    .Fault       (Fault),
    .BusTimeout  (BusTimeout),
    .bus         (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic run_req(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          rdy_at,
    input int          exp_acc,
    input logic [3:0]  be,
    input logic [31:0] bwd,
    input bit          chk_wd,
    input logic        flt,
    input logic        tmo,
    input logic [31:0] rdo,
    input bit          chk_rdo,
    input int          exp_stall
  );
    exp_t e;
    int   acc;
    int   stl;
    bit   done;
    acc  = 0;
    stl  = 0;
    done = 0;
    e.fault   = flt;
    e.tmo     = tmo;
    e.rdo     = rdo;
    e.chk_rdo = chk_rdo;
    @(posedge CLK);
    #1;
    MemReq    = 1'b1;
    MemWrite  = we;
    Funct3    = f3;
    ALUResult = addr;
    WriteData = wd;
    bus.BusRData = rd;
    sb.push_back(e);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge CLK);
      if (Stall) stl++;
      if (bus.BusValid) begin
        acc++;
        check({tag, "_addr"}, bus.BusAddr,
              {addr[31:2], 2'b00});
        check({tag, "_be"}, {28'd0, bus.BusByteEn},
              {28'd0, be});
        check({tag, "_wr"}, {31'd0, bus.BusWrite},
              {31'd0, we});
        if (chk_wd)
          check({tag, "_wd"}, bus.BusWData, bwd);
      end
      bus.BusReady = bus.BusValid && (acc == rdy_at);
      if (!Stall) begin
        e = sb.pop_front();
        check({tag, "_fault"}, {31'd0, Fault},
              {31'd0, e.fault});
        check({tag, "_tmo"}, {31'd0, BusTimeout},
              {31'd0, e.tmo});
        if (e.chk_rdo)
          check({tag, "_rdo"}, ReadDataOut, e.rdo);
        done = 1;
      end
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_acc"}, acc, exp_acc);
    check({tag, "_stall"}, stl, exp_stall);
    @(posedge CLK);
    #1;
    MemReq       = 1'b0;
    bus.BusReady = 1'b0;
    @(negedge CLK);
    check({tag, "_pulse"}, {30'd0, Fault, BusTimeout},
          32'd0);
    check({tag, "_idle"}, {31'd0, Stall}, 32'd0);
  endtask

  initial begin
    int acc;
    tests        = 0;
    fails        = 0;
    RESET        = 1'b0;
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    Funct3       = 3'b000;
    ALUResult    = 32'd0;
    WriteData    = 32'd0;
    bus.BusReady = 1'b0;
    bus.BusRData = 32'd0;
    repeat (3) @(negedge CLK);
    check("rst_valid", {31'd0, bus.BusValid}, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_fault", {31'd0, Fault}, 32'd0);
    check("rst_tmo", {31'd0, BusTimeout}, 32'd0);
    check("rst_rdo", ReadDataOut, 32'd0);
    check("rst_be", {28'd0, bus.BusByteEn}, 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b1;

    run_req("sw", 1, F3_W, 32'h1000_0008, 32'hDEAD_BEEF,
            32'd0, 1, 1, 4'b1111, 32'hDEAD_BEEF, 1,
            0, 0, 32'd0, 0, 2);
    run_req("sb", 1, F3_B, 32'h1000_0003, 32'h0000_00A5,
            32'd0, 1, 1, 4'b1000, 32'hA5A5_A5A5, 1,
            0, 0, 32'd0, 0, 2);
    run_req("sh", 1, F3_H, 32'h1000_0002, 32'h0000_1234,
            32'd0, 1, 1, 4'b1100, 32'h1234_1234, 1,
            0, 0, 32'd0, 0, 2);
    run_req("lb", 0, F3_B, 32'h2000_0003, 32'd0,
            32'h80F1_7F22, 1, 1, 4'b1111, 32'd0, 0,
            0, 0, 32'hFFFF_FF80, 1, 2);
    run_req("lbu", 0, F3_BU, 32'h2000_0003, 32'd0,
            32'h80F1_7F22, 1, 1, 4'b1111, 32'd0, 0,
            0, 0, 32'h0000_0080, 1, 2);
    run_req("lh", 0, F3_H, 32'h2000_0002, 32'd0,
            32'h80F1_7F22, 1, 1, 4'b1111, 32'd0, 0,
            0, 0, 32'hFFFF_80F1, 1, 2);
    run_req("lhu", 0, F3_HU, 32'h2000_0000, 32'd0,
            32'h80F1_7F22, 1, 1, 4'b1111, 32'd0, 0,
            0, 0, 32'h0000_7F22, 1, 2);
    run_req("lb1", 0, F3_B, 32'h2000_0001, 32'd0,
            32'h80F1_7F22, 1, 1, 4'b1111, 32'd0, 0,
            0, 0, 32'h0000_007F, 1, 2);
    run_req("mis_lw", 0, F3_W, 32'h2000_0002, 32'd0,
            32'd0, 0, 0, 4'b1111, 32'd0, 0,
            1, 0, 32'd0, 1, 1);
    run_req("lw", 0, F3_W, 32'h2000_0004, 32'd0,
            32'h0BAD_F00D, 1, 1, 4'b1111, 32'd0, 0,
            0, 0, 32'h0BAD_F00D, 1, 2);
    run_req("ill_011", 0, 3'b011, 32'h2000_0000, 32'd0,
            32'd0, 0, 0, 4'b1111, 32'd0, 0,
            1, 0, 32'd0, 1, 1);
    run_req("mis_sh", 1, F3_H, 32'h2000_0001, 32'h55,
            32'd0, 0, 0, 4'b1111, 32'd0, 0,
            1, 0, 32'd0, 0, 1);
    run_req("ill_sbu", 1, F3_BU, 32'h2000_0000, 32'h55,
            32'd0, 0, 0, 4'b1111, 32'd0, 0,
            1, 0, 32'd0, 0, 1);
    run_req("sw_slow", 1, F3_W, 32'h3000_0010,
            32'hCAFE_F00D, 32'd0, 5, 5, 4'b1111,
            32'hCAFE_F00D, 1, 0, 0, 32'd0, 0, 6);

    // reset in the third wait cycle of an outstanding store
    @(posedge CLK);
    #1;
    MemReq    = 1'b1;
    MemWrite  = 1'b1;
    Funct3    = F3_W;
    ALUResult = 32'h4000_0000;
    WriteData = 32'h1111_2222;
    acc = 0;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      @(negedge CLK);
      if (bus.BusValid) acc++;
    end
    check("rr_reach", acc, 3);
    #2 RESET = 1'b0;
    #1;
    check("rr_valid", {31'd0, bus.BusValid}, 32'd0);
    check("rr_stall", {31'd0, Stall}, 32'd0);
    MemReq = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    check("rr_idle", {30'd0, bus.BusValid, Stall}, 32'd0);
    run_req("post_rst", 0, F3_W, 32'h4000_0008, 32'd0,
            32'h1357_9BDF, 1, 1, 4'b1111, 32'd0, 0,
            0, 0, 32'h1357_9BDF, 1, 2);

`ifdef LSU_TIMEOUT_EN
    run_req("tmo", 0, F3_W, 32'h5000_0000, 32'd0,
            32'hFFFF_FFFF, 99, 4, 4'b1111, 32'd0, 0,
            0, 1, 32'd0, 1, 5);
    run_req("tmo_edge", 0, F3_W, 32'h5000_0004, 32'd0,
            32'h2468_ACE0, 4, 4, 4'b1111, 32'd0, 0,
            0, 0, 32'h2468_ACE0, 1, 5);
`endif

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the single-cycle datapath's ALU.
- Consumes the effective address (ALUResult), store data (register file read port 2) and funct3.
- Runs a valid/ready transaction on the data-memory bus.
- Returns aligned, sign/zero-extended load data to the Result mux.
- Holds the program counter (drives its EN low) while the access is outstanding.

Parameters:
- ADDR_W, 32, bus address width.
- TIMEOUT_CYCLES, 255, bus wait limit (used only with the optional feature); min 1.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- MemReq  input  1  control: current instruction is a load/store; held stable until Stall drops.
- MemWrite  input  1  1 = store, 0 = load.
- Funct3  input  3  RV32I width/sign code (Instr[14:12]).
- ALUResult  input  32  effective byte address.
- WriteData  input  32  store source register value.
- ReadDataOut  output  32  extended load result to the Result mux.
- Stall  output  1  1 = freeze PC and register writeback; the datapath drives PC EN = ~Stall.
- Fault  output  1  one-cycle pulse: misaligned address or illegal Funct3.
- BusTimeout  output  1  one-cycle pulse: bus did not answer (optional feature).
- BusValid  output  1  request valid.
- BusWrite  output  1  request is a write.
- BusAddr  output  ADDR_W  word-aligned address ({ALUResult[31:2],2'b00}).
- BusWData  output  32  lane-replicated store data.
- BusByteEn  output  4  byte lane enables.
- BusReady  input  1  memory accepts (write) or returns data (read) this cycle.
- BusRData  input  32  read data, valid when BusValid && BusReady.

Behaviour:
- Reset (RESET low, async):
  - state = IDLE.
  - All outputs 0; ReadDataOut register = 0.
  - Mid-transaction reset drops BusValid immediately; no response is owed.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Stall = MemReq.
  - MemReq with legal code and aligned address -> ACCESS; request fields registered at entry.
  - MemReq with illegal or misaligned request -> RESP with fault flag set; no bus activity.
- ACCESS:
  - BusValid = 1; Stall = 1; request fields held constant.
  - BusValid && BusReady -> RESP; load data extended and registered.
- RESP (exactly 1 cycle):
  - Stall = 0, so PC advances and writeback occurs.
  - Fault pulses if flagged; ReadDataOut is valid this cycle.
  - Next state IDLE; a following MemReq is seen the next cycle.
- Minimum latency: 2 stall cycles + 1 RESP cycle, with BusReady high on the first ACCESS cycle.
- Legal Funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal and raise Fault.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Store lanes:
  - SB: BusByteEn = 4'b0001 << addr[1:0]; BusWData = {4{WriteData[7:0]}}.
  - SH: BusByteEn = 4'b0011 << addr[1:0]; BusWData = {2{WriteData[15:0]}}.
  - SW: BusByteEn = 4'b1111.
- Loads:
  - BusByteEn = 4'b1111.
  - Byte/half selected by addr[1:0] and sign- or zero-extended to 32 bits.
- Faulted access: ReadDataOut = 0 and nothing is written.
- ReadDataOut holds its value until the next RESP.
- MemReq low in IDLE: Stall = 0 and the block is transparent.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A wait counter is cleared on ACCESS entry and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES without BusReady: BusValid drops, state -> RESP, BusTimeout pulses in RESP, ReadDataOut = 0.
  - BusReady arriving in the same cycle as the limit wins (normal completion).
- LSU_TIMEOUT_EN undefined:
  - No counter; ACCESS waits indefinitely.
  - BusTimeout tied to 0.

Decomposition:
- Shared package holds:
  - Funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding.
  - The byte-enable table.
- One sub-module is natural: load_extend (combinational lane select plus sign/zero extension); the FSM stays in load_store_unit.

Test Plan:
1. SW: addr 0x1000_0008, data 0xDEADBEEF, BusReady high on the first ACCESS cycle -> BusByteEn=1111, BusWData=0xDEADBEEF, Stall high 2 cycles, then low 1 cycle.
2. SB at 0x...03, data 0x000000A5 -> BusByteEn=1000, BusWData=0xA5A5A5A5. SH at 0x...02, data 0x1234 -> BusByteEn=1100, BusWData=0x12341234.
3. BusRData=0x80F1_7F22:
   - LB at offset 3 -> 0xFFFFFF80.
   - LBU at offset 3 -> 0x00000080.
   - LH at offset 2 -> 0xFFFF80F1.
   - LHU at offset 0 -> 0x00007F22.
4. Misaligned/illegal:
   - LW at 0x...02 -> no BusValid, Fault pulse, ReadDataOut=0, Stall for 1 cycle only.
   - Funct3=011 -> same response.
5. BusReady delayed 5 cycles -> Stall held 6 cycles with BusAddr and BusWData stable. RESET pulled low in cycle 3 of the wait -> BusValid and Stall drop asynchronously and state = IDLE.
6. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, BusReady never asserted -> BusValid drops after 4 ACCESS cycles, BusTimeout pulses for 1 cycle, Stall released.
